// File: rtl/car_collision_pkg.sv
// Shared constants and types for the car collision checker.
package car_collision_pkg;

  localparam int unsigned GAME_WIDTH  = 640;
  localparam int unsigned GAME_HEIGHT = 480;

  localparam logic [1:0] GS_RUNNING = 2'b01;

  localparam int unsigned DEF_CAR_W  = 32;
  localparam int unsigned DEF_CAR_H  = 16;
  localparam int unsigned DEF_FROG_W = 16;
  localparam int unsigned DEF_FROG_H = 16;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StReport
  } state_e;

endpackage

// File: rtl/car_collision_rect_overlap.sv
// Combinational half-open rectangle overlap test for one frog/car pair.
// CAR_WRAP_HIT_EN also tests the segment of a car wrapped past the right edge.
module car_collision_rect_overlap
  import car_collision_pkg::*;
#(
  parameter int unsigned CAR_W  = DEF_CAR_W,
  parameter int unsigned CAR_H  = DEF_CAR_H,
  parameter int unsigned FROG_W = DEF_FROG_W,
  parameter int unsigned FROG_H = DEF_FROG_H
) (
  input  logic [9:0] frog_x,
  input  logic [8:0] frog_y,
  input  logic [9:0] car_x,
  input  logic [8:0] car_y,
  output logic       hit
);

  logic [10:0] car_x_end, frog_x_end;
  logic [9:0]  car_y_end, frog_y_end;
  logic        x_hit, y_hit, wrap_hit;

  // Widened sums so no addition overflows
  assign car_x_end  = {1'b0, car_x} + 11'(CAR_W);
  assign frog_x_end = {1'b0, frog_x} + 11'(FROG_W);
  assign car_y_end  = {1'b0, car_y} + 10'(CAR_H);
  assign frog_y_end = {1'b0, frog_y} + 10'(FROG_H);

`ifdef CAR_WRAP_HIT_EN
  logic [10:0] wrap_end;
  assign wrap_end = car_x_end - 11'(GAME_WIDTH);
  // Overflow segment is [0, wrap_end); the frog interval always starts at or above 0
  assign wrap_hit = (car_x_end > 11'(GAME_WIDTH)) && ({1'b0, frog_x} < wrap_end);
`else
  assign wrap_hit = 1'b0;
`endif

  assign x_hit = (({1'b0, frog_x} < car_x_end) && ({1'b0, car_x} < frog_x_end)) || wrap_hit;
  assign y_hit = ({1'b0, frog_y} < car_y_end) && ({1'b0, car_y} < frog_y_end);
  assign hit   = x_hit && y_hit;

endmodule

// File: rtl/car_collision.sv
// Sequential collision checker: snapshots positions on a frame start and scans one car per clock.
// Optional macro CAR_WRAP_HIT_EN enables hits on the wrapped segment of a car.
module car_collision
  import car_collision_pkg::*;
#(
  parameter int unsigned N_CARS = 8,
  parameter int unsigned CAR_W  = DEF_CAR_W,
  parameter int unsigned CAR_H  = DEF_CAR_H,
  parameter int unsigned FROG_W = DEF_FROG_W,
  parameter int unsigned FROG_H = DEF_FROG_H
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset_n,
  input  logic                  i_frame_start,
  input  logic [1:0]            i_game_state,
  input  logic [9:0]            i_frogX,
  input  logic [8:0]            i_frogY,
  input  logic [10*N_CARS-1:0]  i_carX,
  input  logic [9*N_CARS-1:0]   i_carY,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_hit,
  output logic [3:0]            o_hit_idx
);

  state_e      state_q, state_d;
  logic [9:0]  frog_x_q;
  logic [8:0]  frog_y_q;
  logic [9:0]  car_x_q [N_CARS];
  logic [8:0]  car_y_q [N_CARS];
  logic [3:0]  idx_q;
  logic        hit_q;
  logic [3:0]  hit_idx_q;

  logic        start;
  logic        last_slot;
  logic        overlap;
  logic [9:0]  sel_x;
  logic [8:0]  sel_y;

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int k = 0; k < N_CARS; k++) begin
      if (idx_q == 4'(k)) begin
        sel_x = car_x_q[k];
        sel_y = car_y_q[k];
      end
    end
  end

  car_collision_rect_overlap #(
    .CAR_W  (CAR_W),
    .CAR_H  (CAR_H),
    .FROG_W (FROG_W),
    .FROG_H (FROG_H)
  ) u_overlap (
    .frog_x (frog_x_q),
    .frog_y (frog_y_q),
    .car_x  (sel_x),
    .car_y  (sel_y),
    .hit    (overlap)
  );

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    last_slot = (idx_q == 4'(N_CARS - 1));
    unique case (state_q)
      StIdle: begin
        if (i_frame_start && (i_game_state == GS_RUNNING)) begin
          start   = 1'b1;
          state_d = StScan;
        end
      end
      StScan: begin
        if (last_slot) begin
          state_d = StReport;
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      frog_x_q <= '0;
      frog_y_q <= '0;
      for (int k = 0; k < N_CARS; k++) begin
        car_x_q[k] <= '0;
        car_y_q[k] <= '0;
      end
    end else if (start) begin
      frog_x_q <= i_frogX;
      frog_y_q <= i_frogY;
      for (int k = 0; k < N_CARS; k++) begin
        car_x_q[k] <= i_carX[10*k +: 10];
        car_y_q[k] <= i_carY[9*k +: 9];
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      idx_q     <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
    end else if (start) begin
      idx_q     <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
    end else if (state_q == StScan) begin
      idx_q <= idx_q + 4'd1;
      // First overlap wins; later ones keep the lowest index
      if (overlap && !hit_q) begin
        hit_q     <= 1'b1;
        hit_idx_q <= idx_q;
      end
    end
  end

  assign o_busy    = (state_q == StScan);
  assign o_done    = (state_q == StReport);
  assign o_hit     = o_done && hit_q;
  assign o_hit_idx = (o_done && hit_q) ? hit_idx_q : 4'd0;

endmodule

// File: tb/tb_car_collision.sv
// Self-checking bench for car_collision with a queue-based scoreboard of expected verdicts.
module tb_car_collision;

  localparam int N_CARS = 8;
  localparam int CAR_W  = 32;
  localparam int CAR_H  = 16;
  localparam int FROG_W = 16;
  localparam int FROG_H = 16;
  localparam int LAT    = N_CARS + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 frame_start = 1'b0;
  logic [1:0]           game_state = 2'b00;
  logic [9:0]           frog_x = '0;
  logic [8:0]           frog_y = '0;
  logic [10*N_CARS-1:0] car_x_bus = '0;
  logic [9*N_CARS-1:0]  car_y_bus = '0;
  logic                 busy, done, hit;
  logic [3:0]           hit_idx;

  typedef struct {
    bit hit;
    int idx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;
  int   m_fx, m_fy;
  int   m_cx[N_CARS];
  int   m_cy[N_CARS];

  car_collision dut (
    .i_Clk         (clk),
    .i_Reset_n     (rst_n),
    .i_frame_start (frame_start),
    .i_game_state  (game_state),
    .i_frogX       (frog_x),
    .i_frogY       (frog_y),
    .i_carX        (car_x_bus),
    .i_carY        (car_y_bus),
    .o_busy        (busy),
    .o_done        (done),
    .o_hit         (hit),
    .o_hit_idx     (hit_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_count <= done_count + 1;
  end

  function automatic bit model_overlap(int fx, int fy, int cx, int cy);
    bit xo, yo;
    xo = (fx < cx + CAR_W) && (cx < fx + FROG_W);
`ifdef CAR_WRAP_HIT_EN
    if ((cx + CAR_W > 640) && (fx < cx + CAR_W - 640)) xo = 1'b1;
`endif
    yo = (fy < cy + CAR_H) && (cy < fy + FROG_H);
    return xo && yo;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_positions();
    frog_x = 10'(m_fx);
    frog_y = 9'(m_fy);
    for (int k = 0; k < N_CARS; k++) begin
      car_x_bus[10*k +: 10] = 10'(m_cx[k]);
      car_y_bus[9*k +: 9]   = 9'(m_cy[k]);
    end
  endtask

  task automatic far_cars();
    for (int k = 0; k < N_CARS; k++) begin
      m_cx[k] = 300 + k * 20;
      m_cy[k] = 400;
    end
  endtask

  // Drives positions and a start pulse; leaves the bench in cycle 1 of the scan.
  task automatic start_scan();
    exp_t e;
    apply_positions();
    e.hit = 1'b0;
    e.idx = 0;
    for (int k = 0; k < N_CARS; k++) begin
      if (!e.hit && model_overlap(m_fx, m_fy, m_cx[k], m_cy[k])) begin
        e.hit = 1'b1;
        e.idx = k;
      end
    end
    sb.push_back(e);
    game_state  = 2'b01;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, output int cyc);
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", hit); end
    checks++;
    if (hit_idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", hit_idx); end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_no_hit();
    exp_t e;
    m_fx = 300;
    m_fy = 200;
    for (int k = 0; k < N_CARS; k++) begin
      m_cx[k] = k * 80;
      m_cy[k] = 100;
    end
    start_scan();
    for (int c = 1; c <= N_CARS; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL no_hit_busy cycle %0d: got busy=%b done=%b expected busy=1 done=0",
                 c, busy, done);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_hit_latency: got busy=%b done=%b at cycle %0d expected busy=0 done=1",
               busy, done, LAT);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL no_hit_sb: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      if (hit !== e.hit) begin errors++; $display("FAIL no_hit_hit: got %b expected %b", hit, e.hit); end
    end
    tick();
  endtask

  task automatic test_multi_hit();
    exp_t e;
    int   cyc;
    far_cars();
    m_fx = 100; m_fy = 128;
    m_cx[2] = 90;  m_cy[2] = 128;
    m_cx[5] = 110; m_cy[5] = 130;
    start_scan();
    game_state = 2'b00;  // mid-scan state change must not abort
    wait_done(1, cyc);
    checks++;
    if (cyc !== LAT) begin errors++; $display("FAIL multi_latency: got %0d expected %0d", cyc, LAT); end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL multi_sb: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      if (hit !== e.hit) begin errors++; $display("FAIL multi_hit: got %b expected %b", hit, e.hit); end
      checks++;
      if (hit_idx !== 4'(e.idx)) begin
        errors++; $display("FAIL multi_idx: got %0d expected %0d", hit_idx, e.idx);
      end
    end
    tick();
  endtask

  task automatic test_edge_touch();
    exp_t e;
    int   cyc;
    far_cars();
    m_fx = 100; m_fy = 128;
    m_cx[0] = 68;  m_cy[0] = 128;  // right edge of car meets left edge of frog
    m_cx[1] = 116; m_cy[1] = 128;  // left edge of car meets right edge of frog
    m_cx[2] = 100; m_cy[2] = 112;  // bottom of car meets top of frog
    m_cx[3] = 100; m_cy[3] = 144;  // top of car meets bottom of frog
    start_scan();
    wait_done(1, cyc);
    checks++;
    if (cyc !== LAT) begin errors++; $display("FAIL edge_latency: got %0d expected %0d", cyc, LAT); end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL edge_sb: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      if (hit !== e.hit) begin errors++; $display("FAIL edge_hit: got %b expected %b", hit, e.hit); end
    end
    tick();
  endtask

  task automatic test_ignored_starts();
    exp_t e;
    int   cyc;
    int   dc;
    bit   saw_busy;
    far_cars();
    m_fx = 100; m_fy = 128;
    m_cx[4] = 95; m_cy[4] = 120;
    apply_positions();
    dc = done_count;
    game_state  = 2'b00;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    saw_busy = 1'b0;
    repeat (12) begin
      if (busy === 1'b1) saw_busy = 1'b1;
      tick();
    end
    checks++;
    if (saw_busy || done_count != dc) begin
      errors++;
      $display("FAIL ignored_not_running: got busy_seen=%b dones=%0d expected 0 and 0",
               saw_busy, done_count - dc);
    end
    dc = done_count;
    start_scan();
    tick();
    tick();
    frame_start = 1'b1;  // pulse in cycle 3 of the scan
    tick();
    frame_start = 1'b0;
    wait_done(4, cyc);
    checks++;
    if (cyc !== LAT) begin errors++; $display("FAIL ignored_latency: got %0d expected %0d", cyc, LAT); end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL ignored_sb: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      if (hit !== e.hit || (e.hit && hit_idx !== 4'(e.idx))) begin
        errors++;
        $display("FAIL ignored_result: got hit=%b idx=%0d expected hit=%b idx=%0d",
                 hit, hit_idx, e.hit, e.idx);
      end
    end
    repeat (15) tick();
    checks++;
    if (done_count - dc != 1) begin
      errors++; $display("FAIL ignored_done_count: got %0d expected 1", done_count - dc);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    int   cyc;
    far_cars();
    m_fx = 5; m_fy = 128;
    m_cx[1] = 630; m_cy[1] = 128;
    start_scan();
    wait_done(1, cyc);
    checks++;
    if (cyc !== LAT) begin errors++; $display("FAIL wrap_latency: got %0d expected %0d", cyc, LAT); end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL wrap_sb: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      if (hit !== e.hit || (e.hit && hit_idx !== 4'(e.idx))) begin
        errors++;
        $display("FAIL wrap_result: got hit=%b idx=%0d expected hit=%b idx=%0d",
                 hit, hit_idx, e.hit, e.idx);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_scan();
    exp_t e;
    int   cyc;
    int   dc;
    far_cars();
    m_fx = 200; m_fy = 50;
    m_cx[3] = 190; m_cy[3] = 45;
    apply_positions();
    game_state  = 2'b01;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    dc = done_count;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0 || hit_idx !== 4'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got busy=%b done=%b hit=%b idx=%0d expected all 0",
               busy, done, hit, hit_idx);
    end
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (15) tick();
    checks++;
    if (done_count != dc) begin
      errors++; $display("FAIL midrst_no_done: got %0d dones expected 0", done_count - dc);
    end
    start_scan();
    wait_done(1, cyc);
    checks++;
    if (cyc !== LAT) begin errors++; $display("FAIL midrst_latency: got %0d expected %0d", cyc, LAT); end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL midrst_sb: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      if (hit !== e.hit || (e.hit && hit_idx !== 4'(e.idx))) begin
        errors++;
        $display("FAIL midrst_result: got hit=%b idx=%0d expected hit=%b idx=%0d",
                 hit, hit_idx, e.hit, e.idx);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    int   r;
    for (int it = 0; it < 6; it++) begin
      m_fx = $urandom_range(0, 620);
      m_fy = $urandom_range(0, 480);
      for (int k = 0; k < N_CARS; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, 60);
          m_cx[k] = m_fx - 30 + r;
          if (m_cx[k] < 0) m_cx[k] = 0;
          r = $urandom_range(0, 30);
          m_cy[k] = m_fy - 15 + r;
          if (m_cy[k] < 0) m_cy[k] = 0;
        end else begin
          m_cx[k] = $urandom_range(0, 1023);
          m_cy[k] = $urandom_range(0, 511);
        end
      end
      start_scan();
      wait_done(1, cyc);
      checks++;
      if (cyc !== LAT) begin
        errors++; $display("FAIL b2b_latency it%0d: got %0d expected %0d", it, cyc, LAT);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL b2b_sb it%0d: got empty queue expected one entry", it);
      end else begin
        e = sb.pop_front();
        if (hit !== e.hit || (e.hit && hit_idx !== 4'(e.idx))) begin
          errors++;
          $display("FAIL b2b_result it%0d: got hit=%b idx=%0d expected hit=%b idx=%0d",
                   it, hit, hit_idx, e.hit, e.idx);
        end
      end
      tick();  // cycle N_CARS+2: earliest accepted start
      checks++;
      if (done !== 1'b0 || hit !== 1'b0 || hit_idx !== 4'd0) begin
        errors++;
        $display("FAIL b2b_after_done it%0d: got done=%b hit=%b idx=%0d expected all 0",
                 it, done, hit, hit_idx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_hit();
    test_multi_hit();
    test_edge_touch();
    test_ignored_starts();
    test_wrap();
    test_reset_mid_scan();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
